// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes with zero-extended immediates, fetch FSM
// state encoding and the NOP word.
package cpu_pkg;

    localparam logic [5:0]  OP_ANDI  = 6'h0C;
    localparam logic [5:0]  OP_ORI   = 6'h0D;
    localparam logic [5:0]  OP_XORI  = 6'h0E;
    localparam logic [5:0]  OP_LUI   = 6'h0F;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_t;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic imm_sign_ext(input logic [5:0] opcode);
        return !(opcode inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI});
    endfunction

endpackage

// File: rtl/ifid_decode.sv
// Combinational field split of an instruction word plus the immediate
// extender sign-control decode.
module ifid_decode
    import cpu_pkg::*;
#(
    parameter int IMM_W = 16
) (
    input  logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [IMM_W-1:0] imm16,
    output logic [25:0]      imm26,
    output logic             sign_ext
);

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm16    = instr[IMM_W-1:0];
    assign imm26    = instr[25:0];
    assign sign_ext = imm_sign_ext(instr[31:26]);

endmodule

// File: rtl/fetch_ifid.sv
// Instruction-fetch stage with a one-entry skid buffer feeding the IF/ID
// pipeline register and its field decode.
module fetch_ifid
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMM_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_instr,
    output logic [5:0]       id_opcode,
    output logic [4:0]       id_rs,
    output logic [4:0]       id_rt,
    output logic [4:0]       id_rd,
    output logic [4:0]       id_shamt,
    output logic [5:0]       id_funct,
    output logic [IMM_W-1:0] id_imm16,
    output logic [25:0]      id_imm26,
    output logic             id_sign_ext
);

    fetch_state_t state;
    logic [31:0]  pc_p0;
    logic [31:0]  skid_pc_p0;
    logic [31:0]  skid_instr_p0;
    logic [31:0]  pc_inc;
    logic [31:0]  redirect_tgt;
    logic         accept;

    assign imem_addr    = pc_p0;
    assign pc_inc       = pc_p0 + 32'd4;
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign accept       = (state == FS_FETCH) && imem_ready;

    // The skid buffer is full exactly while the FSM sits in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FS_BOOT;
            imem_req      <= 1'b0;
            pc_p0         <= RESET_PC;
            skid_pc_p0    <= 32'd0;
            skid_instr_p0 <= NOP_WORD;
            id_valid      <= 1'b0;
            id_pc         <= 32'd0;
            id_instr      <= NOP_WORD;
        end else if (redirect_valid) begin
            pc_p0    <= redirect_tgt;
            id_valid <= 1'b0;
            state    <= FS_FETCH;
            imem_req <= 1'b1;
        end else if (flush) begin
            // An accepted response is consumed but never reaches IF/ID.
            if (accept) pc_p0 <= pc_inc;
            id_valid <= 1'b0;
            state    <= FS_FETCH;
            imem_req <= 1'b1;
        end else begin
            case (state)
                FS_BOOT: begin
                    state    <= FS_FETCH;
                    imem_req <= 1'b1;
                end
                FS_FETCH: begin
                    if (stall) begin
                        if (imem_ready) begin
                            skid_pc_p0    <= pc_p0;
                            skid_instr_p0 <= imem_rdata;
                            pc_p0         <= pc_inc;
                            state         <= FS_HOLD;
                            imem_req      <= 1'b0;
                        end
                    end else if (imem_ready) begin
                        id_pc    <= pc_p0;
                        id_instr <= imem_rdata;
                        id_valid <= 1'b1;
                        pc_p0    <= pc_inc;
                    end else begin
                        id_valid <= 1'b0;
                    end
                end
                FS_HOLD: begin
                    if (!stall) begin
                        id_pc    <= skid_pc_p0;
                        id_instr <= skid_instr_p0;
                        id_valid <= 1'b1;
                        state    <= FS_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= FS_BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    ifid_decode #(.IMM_W(IMM_W)) u_decode (
        .instr    (id_instr),
        .opcode   (id_opcode),
        .rs       (id_rs),
        .rt       (id_rt),
        .rd       (id_rd),
        .shamt    (id_shamt),
        .funct    (id_funct),
        .imm16    (id_imm16),
        .imm26    (id_imm26),
        .sign_ext (id_sign_ext)
    );

endmodule

// File: tb/tb_fetch_ifid.sv
// Bench for fetch_ifid: directed scenarios followed by random traffic, all
// checked against a queue-based model of the fetch/skid behaviour.
module tb_fetch_ifid;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic [25:0] id_imm26;
    logic        id_sign_ext;

    fetch_ifid #(.RESET_PC(RST_PC), .IMM_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_shamt       (id_shamt),
        .id_funct       (id_funct),
        .id_imm16       (id_imm16),
        .id_imm26       (id_imm26),
        .id_sign_ext    (id_sign_ext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;
    bit          m_boot;
    bit          m_idv;
    logic [63:0] m_skid[$];

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        if (addr == 32'h0000_3000) return 32'h2008_FFFF;
        if (addr == 32'h0000_3004) return 32'h3108_8000;
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = RST_PC;
        m_id_pc    = 32'd0;
        m_id_instr = 32'd0;
        m_boot     = 1'b1;
        m_idv      = 1'b0;
        m_skid.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
        chk({tag, "_addr"},  imem_addr,            RST_PC);
        chk({tag, "_valid"}, {31'd0, id_valid},    32'd0);
        chk({tag, "_pc"},    id_pc,                32'd0);
        chk({tag, "_instr"}, id_instr,             32'd0);
        chk({tag, "_op"},    {26'd0, id_opcode},   32'd0);
        chk({tag, "_sext"},  {31'd0, id_sign_ext}, 32'd1);
    endtask

    task automatic check_all(input string tag);
        logic [5:0] op;
        bit         req;
        bit         sext;
        op   = m_id_instr[31:26];
        req  = !m_boot && (m_skid.size() == 0);
        sext = !(op >= 6'd12 && op <= 6'd15);
        chk({tag, "_req"},   {31'd0, imem_req}, {31'd0, req});
        chk({tag, "_addr"},  imem_addr,         m_pc);
        chk({tag, "_valid"}, {31'd0, id_valid}, {31'd0, m_idv});
        if (m_idv) begin
            chk({tag, "_pc"},    id_pc,                 m_id_pc);
            chk({tag, "_instr"}, id_instr,              m_id_instr);
            chk({tag, "_op"},    {26'd0, id_opcode},    {26'd0, op});
            chk({tag, "_rs"},    {27'd0, id_rs},        {27'd0, m_id_instr[25:21]});
            chk({tag, "_rt"},    {27'd0, id_rt},        {27'd0, m_id_instr[20:16]});
            chk({tag, "_rd"},    {27'd0, id_rd},        {27'd0, m_id_instr[15:11]});
            chk({tag, "_shamt"}, {27'd0, id_shamt},     {27'd0, m_id_instr[10:6]});
            chk({tag, "_funct"}, {26'd0, id_funct},     {26'd0, m_id_instr[5:0]});
            chk({tag, "_imm16"}, {16'd0, id_imm16},     {16'd0, m_id_instr[15:0]});
            chk({tag, "_imm26"}, {6'd0, id_imm26},      {6'd0, m_id_instr[25:0]});
            chk({tag, "_sext"},  {31'd0, id_sign_ext},  {31'd0, sext});
        end
    endtask

    // Apply one cycle of inputs, advance the model by the fetch rules, compare.
    task automatic step(input string tag, input bit st, input bit fl, input bit rv,
                        input logic [31:0] rpc, input bit rdy);
        bit          req;
        logic [31:0] word;
        logic [63:0] e;
        word           = word_at(m_pc);
        stall          = st;
        flush          = fl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ready     = rdy;
        imem_rdata     = word;
        req            = !m_boot && (m_skid.size() == 0);
        @(posedge clk);
        #1;
        if (rv) begin
            m_pc   = {rpc[31:2], 2'b00};
            m_idv  = 1'b0;
            m_boot = 1'b0;
            m_skid.delete();
        end else if (fl) begin
            if (req && rdy) m_pc = m_pc + 32'd4;
            m_idv  = 1'b0;
            m_boot = 1'b0;
            m_skid.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (st) begin
            if (req && rdy) begin
                m_skid.push_back({m_pc, word});
                m_pc = m_pc + 32'd4;
            end
        end else if (m_skid.size() != 0) begin
            e          = m_skid.pop_front();
            m_id_pc    = e[63:32];
            m_id_instr = e[31:0];
            m_idv      = 1'b1;
        end else if (rdy) begin
            m_id_pc    = m_pc;
            m_id_instr = word;
            m_idv      = 1'b1;
            m_pc       = m_pc + 32'd4;
        end else begin
            m_idv = 1'b0;
        end
        check_all(tag);
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_ready     = 1'b1;
        imem_rdata     = 32'd0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset("reset");
        #3;
        rst_n = 1'b1;

        // Boot, then two back-to-back fetches
        step("boot", 0, 0, 0, 32'd0, 1);
        chk("req_rise", {31'd0, imem_req}, 32'd1);
        step("fetch0", 0, 0, 0, 32'd0, 1);
        chk("first_pc", id_pc, 32'h0000_3000);
        chk("first_imm", {16'd0, id_imm16}, 32'h0000_FFFF);
        chk("first_sext", {31'd0, id_sign_ext}, 32'd1);
        step("fetch1", 0, 0, 0, 32'd0, 1);
        chk("second_op", {26'd0, id_opcode}, 32'h0000_000C);
        chk("second_sext", {31'd0, id_sign_ext}, 32'd0);

        // Stall with memory ready: one word into skid, then released
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 32'd0, 1);
        chk("stall_req", {31'd0, imem_req}, 32'd0);
        step("unstall", 0, 0, 0, 32'd0, 1);
        step("after_skid", 0, 0, 0, 32'd0, 1);
        step("after_skid2", 0, 0, 0, 32'd0, 1);

        // Memory not ready: bubbles, PC frozen
        for (int i = 0; i < 2; i++) step("notready", 0, 0, 0, 32'd0, 0);
        step("resume", 0, 0, 0, 32'd0, 1);

        // Redirect while holding a skid word
        step("to_hold", 1, 0, 0, 32'd0, 1);
        step("hold_redir", 1, 0, 1, 32'h0000_4006, 1);
        chk("redir_addr", imem_addr, 32'h0000_4004);
        step("post_redir", 0, 0, 0, 32'd0, 1);

        // Flush with stall, then flush with redirect
        step("flush_stall", 1, 1, 0, 32'd0, 1);
        step("post_flush", 0, 0, 0, 32'd0, 1);
        step("flush_redir", 0, 1, 1, 32'h0000_5000, 1);
        chk("flush_redir_addr", imem_addr, 32'h0000_5000);
        step("post_fr", 0, 0, 0, 32'd0, 1);

        // PC wrap-around
        step("to_top", 0, 0, 1, 32'hFFFF_FFFC, 0);
        step("wrap", 0, 0, 0, 32'd0, 1);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_pc", id_pc, 32'hFFFF_FFFC);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rand",
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 5,
                 $urandom,
                 $urandom_range(0, 99) < 70);
        end

        // Asynchronous reset mid-stream, off the clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        model_reset();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step("rand2",
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 5,
                 $urandom,
                 $urandom_range(0, 99) < 70);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
